// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared types and constants for the instruction-fetch stage
package if_stage_pkg;

    localparam int OUTST_W_DEF = 2;
    localparam logic [4:0] EXC_ADEL = 5'h04;

    typedef logic [31:0] virt_t;

    typedef struct packed {
        logic       ex;
        logic       bd;
        logic [4:0] excode;
        virt_t      badvaddr;
    } exception_t;

    typedef struct packed {
        logic       valid;
        logic       stall;
        logic       req_ok;
        logic       br_op;
        virt_t      pc;
        exception_t exception;
    } pfs_to_fs_bus_t;

    typedef struct packed {
        logic ex;
        logic eret;
        logic tlb_op;
        logic tlb_refill;
    } pipeline_flush_t;

    typedef struct packed {
        virt_t       pc;
        logic [31:0] inst;
        logic        bd;
        exception_t  exception;
    } fs_to_ds_bus_t;

    function automatic logic flush_any(pipeline_flush_t f);
        return f.ex | f.eret | f.tlb_op;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: pipeline and instruction-response signals around the IF stage
interface if_stage_if;
    import if_stage_pkg::*;

    logic            ds_allowin;
    pfs_to_fs_bus_t  pfs_to_fs_bus;
    pipeline_flush_t pipeline_flush;
    logic            inst_data_ok;
    logic [31:0]     inst_rdata;
    logic            fs_allowin;
    logic            fs_valid;
    logic            fs_to_ds_valid;
    fs_to_ds_bus_t   fs_to_ds_bus;

    modport master (
        output ds_allowin, pfs_to_fs_bus, pipeline_flush, inst_data_ok, inst_rdata,
        input  fs_allowin, fs_valid, fs_to_ds_valid, fs_to_ds_bus
    );

    modport slave (
        input  ds_allowin, pfs_to_fs_bus, pipeline_flush, inst_data_ok, inst_rdata,
        output fs_allowin, fs_valid, fs_to_ds_valid, fs_to_ds_bus
    );

endinterface

// File: rtl/if_resp_tracker.sv
// if_resp_tracker: counts in-flight fetches and drops responses belonging to flushed requests
module if_resp_tracker
    import if_stage_pkg::*;
#(
    parameter int OUTST_W = OUTST_W_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic req_ok,
    input  logic data_ok,
    input  logic flush,
    output logic resp_keep
);

    logic [OUTST_W-1:0] outst, outst_nxt, discard;
    logic discard_zero;

    assign discard_zero = discard == '0;
    assign resp_keep    = data_ok & discard_zero;

    // net in-flight change: a new request and a returning response may coincide
    always_comb outst_nxt = outst + OUTST_W'(req_ok) - OUTST_W'(data_ok);

    // every request still in flight after a flush owes us one response to throw away
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outst   <= '0;
            discard <= '0;
        end else begin
            outst   <= outst_nxt;
            discard <= flush ? outst_nxt : (data_ok && !discard_zero) ? discard - 1'b1 : discard;
        end
    end

    no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn) !(data_ok && outst == '0));

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage, pairs accepted fetches with returned instructions for ID
module if_stage
    import if_stage_pkg::*;
#(
    parameter int OUTST_W = OUTST_W_DEF
) (
    input  logic    clk,
    input  logic    resetn,
    if_stage_if.slave io
);

    logic        flush, fs_valid, fs_ex, fs_ready_go, fs_allowin, to_ds, resp_keep;
    logic        buf_valid;
    logic [31:0] buf_inst;
    virt_t       fs_pc;
    exception_t  fs_exc, pfs_exc;
    logic        unused_bits;

    assign unused_bits = ^{io.pfs_to_fs_bus.stall, io.pfs_to_fs_bus.exception.bd,
                           io.pipeline_flush.tlb_refill};

    assign flush       = flush_any(io.pipeline_flush);
    assign fs_ex       = fs_exc.ex;
    assign fs_ready_go = fs_ex | buf_valid | resp_keep;
    assign fs_allowin  = !fs_valid | (fs_ready_go & io.ds_allowin);
    assign to_ds       = fs_valid & fs_ready_go & !flush;

    assign io.fs_allowin     = fs_allowin;
    assign io.fs_valid       = fs_valid;
    assign io.fs_to_ds_valid = to_ds;

    if_resp_tracker #(.OUTST_W(OUTST_W)) u_tracker (
        .clk       (clk),
        .resetn    (resetn),
        .req_ok    (io.pfs_to_fs_bus.req_ok),
        .data_ok   (io.inst_data_ok),
        .flush     (flush),
        .resp_keep (resp_keep)
    );

    // the delay-slot flag travels inside the exception record so ID sees one consistent bd
    always_comb begin
        pfs_exc    = io.pfs_to_fs_bus.exception;
        pfs_exc.bd = io.pfs_to_fs_bus.br_op;
    end

    // output bus: exception entries carry no instruction; buffered word wins over the live bypass
    always_comb begin
        io.fs_to_ds_bus.pc        = fs_pc;
        io.fs_to_ds_bus.inst      = (fs_ex || !fs_valid) ? 32'd0 : buf_valid ? buf_inst : io.inst_rdata;
        io.fs_to_ds_bus.bd        = fs_exc.bd;
        io.fs_to_ds_bus.exception = fs_exc;
    end

    // stage register: flush beats any capture, otherwise refill whenever IF frees up
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_valid <= 1'b0;
            fs_pc    <= '0;
            fs_exc   <= '0;
        end else if (flush) begin
            fs_valid <= 1'b0;
        end else if (fs_allowin) begin
            fs_valid <= io.pfs_to_fs_bus.valid;
            if (io.pfs_to_fs_bus.valid) begin
                fs_pc  <= io.pfs_to_fs_bus.pc;
                fs_exc <= pfs_exc;
            end
        end
    end

    // single-entry buffer holds a live response while ID is stalled
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
            buf_inst  <= '0;
        end else if (flush || (to_ds && io.ds_allowin)) begin
            buf_valid <= 1'b0;
        end else if (resp_keep && fs_valid && !fs_ex && !io.ds_allowin) begin
            buf_valid <= 1'b1;
            buf_inst  <= io.inst_rdata;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenarios plus randomized traffic against a transaction-level model
module tb_if_stage;
    import if_stage_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    if_stage_if ifc();

    if_stage dut (.clk(clk), .resetn(resetn), .io(ifc));

    always #5 clk = ~clk;

    // model: the entry sitting in IF, whether its word has arrived, and one flag per in-flight request
    bit          m_have, m_got, m_ex, m_bd;
    logic [31:0] m_pc, m_inst;
    logic [4:0]  m_code;
    bit          stale_q[$];

    function automatic bit m_flush();
        return ifc.pipeline_flush.ex || ifc.pipeline_flush.eret || ifc.pipeline_flush.tlb_op;
    endfunction

    function automatic bit m_ready();
        return m_ex || m_got || (ifc.inst_data_ok && stale_q.size() > 0 && !stale_q[0]);
    endfunction

    task automatic drive(bit v, bit req, bit br, logic [31:0] pc, bit ex, bit dok,
                         logic [31:0] rd, bit dsa, logic [2:0] fl);
        ifc.pfs_to_fs_bus.valid     = v;
        ifc.pfs_to_fs_bus.stall     = 1'b0;
        ifc.pfs_to_fs_bus.req_ok    = req;
        ifc.pfs_to_fs_bus.br_op     = br;
        ifc.pfs_to_fs_bus.pc        = pc;
        ifc.pfs_to_fs_bus.exception = '{ex: ex, bd: 1'b0, excode: ex ? EXC_ADEL : 5'd0,
                                        badvaddr: ex ? pc : 32'd0};
        ifc.pipeline_flush          = '{ex: fl[2], eret: fl[1], tlb_op: fl[0], tlb_refill: 1'b0};
        ifc.inst_data_ok            = dok;
        ifc.inst_rdata              = rd;
        ifc.ds_allowin              = dsa;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 32'd0, 0, 0, $urandom, 1, 3'b000);
    endtask

    task automatic tick();
        bit rdy, alw, fl, fresh;
        rdy   = m_ready();
        fl    = m_flush();
        alw   = !m_have || (rdy && ifc.ds_allowin);
        fresh = ifc.inst_data_ok && stale_q.size() > 0 && !stale_q[0];
        @(posedge clk);
        if (ifc.inst_data_ok && stale_q.size() > 0) void'(stale_q.pop_front());
        if (fl) begin
            foreach (stale_q[i]) stale_q[i] = 1'b1;
            m_have = 0;
            m_got  = 0;
            if (ifc.pfs_to_fs_bus.req_ok) stale_q.push_back(1'b1);
        end else begin
            if (ifc.pfs_to_fs_bus.req_ok) stale_q.push_back(1'b0);
            if (alw) begin
                m_have = ifc.pfs_to_fs_bus.valid;
                m_got  = 0;
                if (ifc.pfs_to_fs_bus.valid) begin
                    m_pc   = ifc.pfs_to_fs_bus.pc;
                    m_ex   = ifc.pfs_to_fs_bus.exception.ex;
                    m_code = ifc.pfs_to_fs_bus.exception.excode;
                    m_bd   = ifc.pfs_to_fs_bus.br_op;
                end
            end else if (fresh && !m_ex) begin
                m_got  = 1;
                m_inst = ifc.inst_rdata;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        idle();
        m_have = 0; m_got = 0; m_ex = 0; m_bd = 0; stale_q.delete();
        n_chk++; if (ifc.fs_valid !== 1'b0) $display("FAIL reset_fs_valid got %b exp 0", ifc.fs_valid); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_valid !== 1'b0) $display("FAIL reset_to_ds_valid got %b exp 0", ifc.fs_to_ds_valid); else n_pass++;
        n_chk++; if (ifc.fs_allowin !== 1'b1) $display("FAIL reset_allowin got %b exp 1", ifc.fs_allowin); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.pc !== 32'd0) $display("FAIL reset_pc got %h exp 0", ifc.fs_to_ds_bus.pc); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.inst !== 32'd0) $display("FAIL reset_inst got %h exp 0", ifc.fs_to_ds_bus.inst); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.exception.ex !== 1'b0) $display("FAIL reset_ex got %b exp 0", ifc.fs_to_ds_bus.exception.ex); else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_straight();
        drive(1, 1, 0, 32'hbfc00000, 0, 0, 32'd0, 1, 3'b000);
        tick();
        drive(0, 0, 0, 32'd0, 0, 1, 32'h3c1d0001, 1, 3'b000);
        n_chk++; if (ifc.fs_to_ds_valid !== 1'b1) $display("FAIL straight_valid got %b exp 1", ifc.fs_to_ds_valid); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.pc !== 32'hbfc00000) $display("FAIL straight_pc got %h exp bfc00000", ifc.fs_to_ds_bus.pc); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.inst !== 32'h3c1d0001) $display("FAIL straight_inst got %h exp 3c1d0001", ifc.fs_to_ds_bus.inst); else n_pass++;
        n_chk++; if (ifc.fs_allowin !== 1'b1) $display("FAIL straight_allowin got %b exp 1", ifc.fs_allowin); else n_pass++;
        tick();
        idle();
        n_chk++; if (ifc.fs_valid !== 1'b0) $display("FAIL straight_drained got %b exp 0", ifc.fs_valid); else n_pass++;
    endtask

    task automatic test_back_pressure();
        drive(1, 1, 0, 32'hbfc00004, 0, 0, 32'd0, 1, 3'b000);
        tick();
        drive(0, 0, 0, 32'd0, 0, 1, 32'h24080005, 0, 3'b000);
        n_chk++; if (ifc.fs_allowin !== 1'b0) $display("FAIL bp_allowin0 got %b exp 0", ifc.fs_allowin); else n_pass++;
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 32'd0, 0, 0, $urandom, 0, 3'b000);
            n_chk++; if (ifc.fs_allowin !== 1'b0) $display("FAIL bp_allowin_hold got %b exp 0", ifc.fs_allowin); else n_pass++;
            n_chk++; if (ifc.fs_to_ds_bus.inst !== 32'h24080005) $display("FAIL bp_buf_inst got %h exp 24080005", ifc.fs_to_ds_bus.inst); else n_pass++;
            tick();
        end
        drive(0, 0, 0, 32'd0, 0, 0, $urandom, 1, 3'b000);
        n_chk++; if (ifc.fs_to_ds_valid !== 1'b1) $display("FAIL bp_release_valid got %b exp 1", ifc.fs_to_ds_valid); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.inst !== 32'h24080005) $display("FAIL bp_release_inst got %h exp 24080005", ifc.fs_to_ds_bus.inst); else n_pass++;
        n_chk++; if (ifc.fs_allowin !== 1'b1) $display("FAIL bp_release_allowin got %b exp 1", ifc.fs_allowin); else n_pass++;
        tick();
        idle();
        n_chk++; if (ifc.fs_to_ds_valid !== 1'b0) $display("FAIL bp_once got %b exp 0", ifc.fs_to_ds_valid); else n_pass++;
    endtask

    task automatic test_flush_wait();
        drive(1, 1, 0, 32'h80000100, 0, 0, 32'd0, 1, 3'b000);
        tick();
        drive(0, 0, 0, 32'd0, 0, 0, 32'd0, 1, 3'b100);
        n_chk++; if (ifc.fs_to_ds_valid !== 1'b0) $display("FAIL fw_flush_valid got %b exp 0", ifc.fs_to_ds_valid); else n_pass++;
        tick();
        drive(1, 1, 0, 32'hbfc0037c, 0, 0, 32'd0, 1, 3'b000);
        n_chk++; if (ifc.fs_valid !== 1'b0) $display("FAIL fw_killed got %b exp 0", ifc.fs_valid); else n_pass++;
        tick();
        drive(0, 0, 0, 32'd0, 0, 1, 32'hdeadbeef, 1, 3'b000);
        n_chk++; if (ifc.fs_to_ds_valid !== 1'b0) $display("FAIL fw_drop_valid got %b exp 0", ifc.fs_to_ds_valid); else n_pass++;
        n_chk++; if (ifc.fs_allowin !== 1'b0) $display("FAIL fw_drop_allowin got %b exp 0", ifc.fs_allowin); else n_pass++;
        tick();
        drive(0, 0, 0, 32'd0, 0, 1, 32'h3c1d0002, 1, 3'b000);
        n_chk++; if (ifc.fs_to_ds_valid !== 1'b1) $display("FAIL fw_new_valid got %b exp 1", ifc.fs_to_ds_valid); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.pc !== 32'hbfc0037c) $display("FAIL fw_new_pc got %h exp bfc0037c", ifc.fs_to_ds_bus.pc); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.inst !== 32'h3c1d0002) $display("FAIL fw_new_inst got %h exp 3c1d0002", ifc.fs_to_ds_bus.inst); else n_pass++;
        tick();
        idle();
    endtask

    task automatic test_flush_same_cycle();
        drive(1, 1, 0, 32'h80000200, 0, 0, 32'd0, 1, 3'b000);
        tick();
        drive(1, 1, 0, 32'h80000204, 0, 0, 32'd0, 1, 3'b010);
        n_chk++; if (ifc.fs_to_ds_valid !== 1'b0) $display("FAIL fs_flush_valid got %b exp 0", ifc.fs_to_ds_valid); else n_pass++;
        tick();
        drive(1, 1, 0, 32'hbfc00380, 0, 0, 32'd0, 1, 3'b000);
        n_chk++; if (ifc.fs_valid !== 1'b0) $display("FAIL fs_not_captured got %b exp 0", ifc.fs_valid); else n_pass++;
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 32'd0, 0, 1, $urandom, 1, 3'b000);
            n_chk++; if (ifc.fs_to_ds_valid !== 1'b0) $display("FAIL fs_drop%0d got %b exp 0", i, ifc.fs_to_ds_valid); else n_pass++;
            tick();
        end
        drive(0, 0, 0, 32'd0, 0, 1, 32'h8c820000, 1, 3'b000);
        n_chk++; if (ifc.fs_to_ds_valid !== 1'b1) $display("FAIL fs_third_valid got %b exp 1", ifc.fs_to_ds_valid); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.pc !== 32'hbfc00380) $display("FAIL fs_third_pc got %h exp bfc00380", ifc.fs_to_ds_bus.pc); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.inst !== 32'h8c820000) $display("FAIL fs_third_inst got %h exp 8c820000", ifc.fs_to_ds_bus.inst); else n_pass++;
        tick();
        idle();
    endtask

    task automatic test_exception();
        drive(1, 0, 0, 32'hbfc00002, 1, 0, 32'd0, 1, 3'b000);
        tick();
        drive(0, 0, 0, 32'd0, 0, 0, 32'h12345678, 1, 3'b000);
        n_chk++; if (ifc.fs_to_ds_valid !== 1'b1) $display("FAIL exc_valid got %b exp 1", ifc.fs_to_ds_valid); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.exception.ex !== 1'b1) $display("FAIL exc_ex got %b exp 1", ifc.fs_to_ds_bus.exception.ex); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.exception.excode !== EXC_ADEL) $display("FAIL exc_code got %h exp %h", ifc.fs_to_ds_bus.exception.excode, EXC_ADEL); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.inst !== 32'd0) $display("FAIL exc_inst got %h exp 0", ifc.fs_to_ds_bus.inst); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.pc !== 32'hbfc00002) $display("FAIL exc_pc got %h exp bfc00002", ifc.fs_to_ds_bus.pc); else n_pass++;
        tick();
        idle();
    endtask

    task automatic test_delay_slot();
        drive(1, 1, 1, 32'hbfc00010, 0, 0, 32'd0, 1, 3'b000);
        tick();
        drive(1, 0, 1, 32'hbfc00014, 1, 1, 32'h27bdfff8, 1, 3'b000);
        n_chk++; if (ifc.fs_to_ds_bus.bd !== 1'b1) $display("FAIL ds_bd got %b exp 1", ifc.fs_to_ds_bus.bd); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.exception.bd !== 1'b1) $display("FAIL ds_exc_bd got %b exp 1", ifc.fs_to_ds_bus.exception.bd); else n_pass++;
        n_chk++; if (ifc.fs_to_ds_bus.inst !== 32'h27bdfff8) $display("FAIL ds_inst got %h exp 27bdfff8", ifc.fs_to_ds_bus.inst); else n_pass++;
        tick();
        idle();
        n_chk++; if (ifc.fs_to_ds_bus.exception.ex !== 1'b1 || ifc.fs_to_ds_bus.exception.bd !== 1'b1)
            $display("FAIL ds_exc_entry got ex=%b bd=%b exp 1/1", ifc.fs_to_ds_bus.exception.ex, ifc.fs_to_ds_bus.exception.bd); else n_pass++;
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            bit dok, dsa, v, ex, req, br, rdy, alw, exp_to;
            logic [2:0] fl;
            logic [31:0] rd, pc, exp_inst;
            dok = stale_q.size() > 0 && $urandom_range(0, 2) != 0;
            dsa = $urandom_range(0, 3) != 0;
            fl  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            rd  = $urandom;
            rdy = m_ex || m_got || (dok && stale_q.size() > 0 && !stale_q[0]);
            alw = !m_have || (rdy && dsa);
            v   = $urandom_range(0, 2) != 0;
            ex  = v && $urandom_range(0, 7) == 0;
            br  = $urandom_range(0, 3) == 0;
            pc  = {$urandom} & 32'hfffffffc;
            req = v && !ex && alw;
            if (v && !ex && (!alw || stale_q.size() + int'(req) - int'(dok) > 3)) begin
                v = 0;
                req = 0;
            end
            drive(v, req, br, pc, ex, dok, rd, dsa, fl);
            exp_to   = m_have && rdy && fl == 3'b000;
            exp_inst = m_ex ? 32'd0 : m_got ? m_inst : rd;
            n_chk++; if (ifc.fs_valid !== m_have) $display("FAIL rnd_fs_valid c%0d got %b exp %b", c, ifc.fs_valid, m_have); else n_pass++;
            n_chk++; if (ifc.fs_to_ds_valid !== exp_to) $display("FAIL rnd_to_ds_valid c%0d got %b exp %b", c, ifc.fs_to_ds_valid, exp_to); else n_pass++;
            n_chk++; if (ifc.fs_allowin !== alw) $display("FAIL rnd_allowin c%0d got %b exp %b", c, ifc.fs_allowin, alw); else n_pass++;
            if (exp_to) begin
                n_chk++; if (ifc.fs_to_ds_bus.pc !== m_pc) $display("FAIL rnd_pc c%0d got %h exp %h", c, ifc.fs_to_ds_bus.pc, m_pc); else n_pass++;
                n_chk++; if (ifc.fs_to_ds_bus.inst !== exp_inst) $display("FAIL rnd_inst c%0d got %h exp %h", c, ifc.fs_to_ds_bus.inst, exp_inst); else n_pass++;
                n_chk++; if (ifc.fs_to_ds_bus.exception.ex !== m_ex || ifc.fs_to_ds_bus.bd !== m_bd || ifc.fs_to_ds_bus.exception.bd !== m_bd)
                    $display("FAIL rnd_flags c%0d got ex=%b bd=%b/%b exp ex=%b bd=%b", c, ifc.fs_to_ds_bus.exception.ex,
                             ifc.fs_to_ds_bus.bd, ifc.fs_to_ds_bus.exception.bd, m_ex, m_bd); else n_pass++;
                if (m_ex) begin
                    n_chk++; if (ifc.fs_to_ds_bus.exception.excode !== m_code) $display("FAIL rnd_code c%0d got %h exp %h", c, ifc.fs_to_ds_bus.exception.excode, m_code); else n_pass++;
                end
            end
            tick();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_straight();
        test_back_pressure();
        test_flush_wait();
        test_flush_same_cycle();
        test_exception();
        test_delay_slot();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
